mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_burst_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 80 ++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared controller constants -- arbiter owner/state codes and CPU FSM state codes.
package mem_arbiter_pkg;

    // Arbiter state doubles as the owner code seen on the owner status port.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CPU  = 2'b01,
        ARB_DMA  = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        CPU_FETCH  = 2'b00,
        CPU_DECODE = 2'b01,
        CPU_EXEC   = 2'b10,
        CPU_MEM    = 2'b11
    } cpu_state_t;

    // Wide enough for MAX_BURST up to 16.
    localparam int BURST_W = 4;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// burst_counter: saturating count of granted cycles for the current owner, flags the burst limit.
module burst_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [BURST_W-1:0] LAST = BURST_W'(MAX_BURST - 1);

    logic [BURST_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !at_max)
            count <= count + 1'b1;
    end

    assign at_max = count == LAST;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU/DMA) arbiter onto a single synchronous-read memory with bounded bursts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    arb_state_t state, state_nx, last_owner;
    logic       at_max;
    logic       changing;

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE: state_nx = (cpu_req && dma_req) ? (last_owner == ARB_CPU ? ARB_DMA : ARB_CPU) :
                                 cpu_req ? ARB_CPU : dma_req ? ARB_DMA : ARB_IDLE;
            // Stay while requesting unless the burst limit is hit with the other side waiting.
            ARB_CPU:  state_nx = (cpu_req && !(at_max && dma_req)) ? ARB_CPU : dma_req ? ARB_DMA : ARB_IDLE;
            ARB_DMA:  state_nx = (dma_req && !(at_max && cpu_req)) ? ARB_DMA : cpu_req ? ARB_CPU : ARB_IDLE;
            default:  state_nx = ARB_IDLE;
        endcase
    end

    assign changing = state_nx != state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_owner <= ARB_DMA;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            state      <= state_nx;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
            if (changing && state != ARB_IDLE)
                last_owner <= state;
        end
    end

    burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
        .clk    (clk),
        .reset  (reset),
        .clr    (changing),
        .inc    (cpu_gnt || dma_gnt),
        .at_max (at_max)
    );

    assign cpu_gnt   = state == ARB_CPU && cpu_req;
    assign dma_gnt   = state == ARB_DMA && dma_req;
    assign mem_we    = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
    assign mem_addr  = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
    assign mem_wdata = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    assign rdata     = mem_rdata;
    assign owner     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a per-cycle ownership/memory model plus literal spot checks.
module tb_mem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    int          m_own, m_last, m_run;
    logic        m_crv, m_drv;
    logic [31:0] m_rexp;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .rdata      (rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .owner      (owner)
    );

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:2]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: owner 0/1/2, m_run = grants given to the current owner this tenure.
    always @(negedge clk) begin
        logic        e_cg, e_dg, e_we, own_r, oth_r;
        logic [31:0] e_addr, e_wd;
        if (!reset) begin
            m_own = 0; m_last = 2; m_run = 0; m_crv = 0; m_drv = 0;
            chk("rst_owner", owner, 0);
            chk("rst_gnt", {cpu_gnt, dma_gnt}, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        end else begin
            e_cg   = m_own == 1 && cpu_req;
            e_dg   = m_own == 2 && dma_req;
            e_we   = (e_cg && cpu_we) || (e_dg && dma_we);
            e_addr = e_cg ? cpu_addr : e_dg ? dma_addr : 32'h0;
            e_wd   = e_cg ? cpu_wdata : e_dg ? dma_wdata : 32'h0;
            chk("m_owner", owner, m_own[1:0]);
            chk("m_cpu_gnt", cpu_gnt, e_cg);
            chk("m_dma_gnt", dma_gnt, e_dg);
            chk("m_mem_we", mem_we, e_we);
            chk("m_mem_addr", mem_addr, e_addr);
            chk("m_mem_wdata", mem_wdata, e_wd);
            chk("m_cpu_rvalid", cpu_rvalid, m_crv);
            chk("m_dma_rvalid", dma_rvalid, m_drv);
            if (m_crv || m_drv)
                chk("m_rdata", rdata, m_rexp);
            m_crv = e_cg && !cpu_we;
            m_drv = e_dg && !dma_we;
            if (e_cg || e_dg) begin
                if (e_we)
                    shadow[e_addr[11:2]] = e_wd;
                else
                    m_rexp = shadow[e_addr[11:2]];
            end
            if (m_own == 0) begin
                if (cpu_req && dma_req)
                    m_own = m_last == 1 ? 2 : 1;
                else if (cpu_req)
                    m_own = 1;
                else if (dma_req)
                    m_own = 2;
                m_run = 0;
            end else begin
                own_r = m_own == 1 ? cpu_req : dma_req;
                oth_r = m_own == 1 ? dma_req : cpu_req;
                if (own_r)
                    m_run++;
                if (!own_r || (m_run >= MAXB && oth_r)) begin
                    m_last = m_own;
                    m_own  = oth_r ? 3 - m_own : 0;
                    m_run  = 0;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'hC0DE_0000 + i;
            shadow[i] = 32'hC0DE_0000 + i;
        end
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h1111_1111;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80; dma_wdata = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("hold_owner", owner, 2'b00);
            chk("hold_gnt", {cpu_gnt, dma_gnt}, 2'b00);
            nxt();
        end
        reset = 1'b1;
        smp();
        chk("rel_cyc1_cpu_gnt", cpu_gnt, 0);
        nxt();
        for (int i = 0; i < 12; i++) begin
            smp();
            chk($sformatf("burst%0d_cpu", i), cpu_gnt, (i < 4 || i >= 8));
            chk($sformatf("burst%0d_dma", i), dma_gnt, (i >= 4 && i < 8));
            nxt();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        nxt(); nxt();
        smp();
        chk("burst_end_idle", owner, 2'b00);

        nxt();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        smp();
        chk("rd_lat_gnt", cpu_gnt, 0);
        nxt();
        smp();
        chk("rd_gnt", cpu_gnt, 1);
        chk("rd_addr", mem_addr, 32'h20);
        chk("rd_we", mem_we, 0);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("rd_rvalid", cpu_rvalid, 1);
        chk("rd_rdata", rdata, 32'hC0DE_0008);

        nxt();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hDEAD_BEEF;
        smp();
        chk("wr_pre_we", mem_we, 0);
        nxt();
        smp();
        chk("wr_gnt", dma_gnt, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        nxt();
        dma_req = 1'b0; dma_we = 1'b0;
        smp();
        chk("wr_post_we", mem_we, 0);
        nxt();
        cpu_req = 1'b1; cpu_addr = 32'h100;
        nxt();
        smp();
        chk("rb_gnt", cpu_gnt, 1);
        nxt();
        cpu_req = 1'b0;
        smp();
        chk("rb_rvalid", cpu_rvalid, 1);
        chk("rb_rdata", rdata, 32'hDEAD_BEEF);

        nxt(); nxt();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
        nxt();
        smp();
        chk("mr_gnt1", dma_gnt, 1);
        nxt();
        #2;
        chk("mr_gnt2", dma_gnt, 1);
        reset = 1'b0;
        cpu_req = 1'b1;
        #1;
        chk("mr_gnt_fall", dma_gnt, 0);
        chk("mr_rvalid_clr", dma_rvalid, 0);
        nxt(); nxt();
        reset = 1'b1;
        smp();
        chk("mr_rel_rvalid", dma_rvalid, 0);
        nxt();
        smp();
        chk("mr_cpu_first", cpu_gnt, 1);
        chk("mr_dma_wait", dma_gnt, 0);
        chk("mr_no_rvalid", dma_rvalid, 0);
        nxt();
        cpu_req = 1'b0; dma_req = 1'b0;
        nxt(); nxt();

        cpu_req = 1'b1; cpu_addr = 32'h40;
        nxt(); nxt(); nxt();
        cpu_req = 1'b0;
        smp();
        chk("drop_still_cpu", owner, 2'b01);
        nxt();
        smp();
        chk("drop_idle", owner, 2'b00);
        cpu_req = 1'b1;
        nxt(); nxt(); nxt();
        cpu_req = 1'b0; dma_req = 1'b1;
        smp();
        chk("handoff_owner", owner, 2'b01);
        nxt();
        smp();
        chk("handoff_dma", owner, 2'b10);
        chk("handoff_gnt", dma_gnt, 1);
        nxt();
        dma_req = 1'b0;
        nxt(); nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
